// File: rtl/uart_rx_param_if.sv
// Receive-side handshake bundle for uart_rx_param: serial input, delivered word with status,
// and the consumer's ready. The receiver is the master; the consumer is the slave.
`timescale 1ns/1ps
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rxd, rx_ready,
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy
    );

    modport slave (
        output rxd, rx_ready,
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled rxd, 3-sample mid-bit majority vote, 5-9 data bits,
// optional parity, 1/2 stop bits, valid/ready output register with frame/parity/overrun status.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int CLK_PER_TICK = 27,
    parameter int OS           = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_param_if.master bus
);
    localparam int TCW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int OSW = $clog2(OS);

    localparam logic [TCW-1:0] TICK_LAST = TCW'(CLK_PER_TICK - 1);
    localparam logic [OSW-1:0] OS_LAST   = OSW'(OS - 1);
    localparam logic [OSW-1:0] OS_V0     = OSW'(OS / 2 - 1);
    localparam logic [OSW-1:0] OS_V1     = OSW'(OS / 2);
    localparam logic [OSW-1:0] OS_SAMPLE = OSW'(OS / 2 + 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state;
    logic                 r_sync1, r_sync2, r_rxs_d;
    logic [TCW-1:0]       r_tick_cnt;
    logic [OSW-1:0]       r_os_cnt;
    logic [3:0]           r_bit_cnt;
    logic                 r_v0, r_v1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr, r_perr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_frame_err, r_parity_err, r_overrun, r_busy;

    logic w_rxs, w_fall, w_tick, w_vote, w_sample, w_bit_end, w_done;

    // NOTE: the synchroniser and edge-detect flops reset to the idle level (1) so that leaving
    // reset never looks like a falling start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
        end
    end

    assign w_rxs     = r_sync2;
    assign w_fall    = r_rxs_d & ~r_sync2;
    assign w_tick    = (r_tick_cnt == TICK_LAST);
    assign w_vote    = (r_v0 & r_v1) | (r_v0 & w_rxs) | (r_v1 & w_rxs);
    assign w_sample  = w_tick && (r_os_cnt == OS_SAMPLE);
    assign w_bit_end = w_tick && (r_os_cnt == OS_LAST);
    assign w_done    = (r_state == S_STOP) && w_sample && (r_bit_cnt == STOP_LAST);

    // NOTE: every register here is state, so all updates are non-blocking; later assignments
    // in the same clock (e.g. counter restart on a start edge) override the default ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_v0         <= 1'b1;
            r_v1         <= 1'b1;
            r_shift      <= '0;
            r_ferr       <= 1'b0;
            r_perr       <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_overrun  <= 1'b0;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
                if (r_os_cnt == OS_V0) r_v0 <= w_rxs;
                if (r_os_cnt == OS_V1) r_v1 <= w_rxs;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state    <= S_START;
                        r_busy     <= 1'b1;
                        r_tick_cnt <= '0;
                        r_os_cnt   <= '0;
                        r_ferr     <= 1'b0;
                        r_perr     <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_sample && w_vote) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_sample) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_bit_end) begin
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_sample)
                        r_perr <= (PARITY == 1) ? (^{r_shift, w_vote}) : ~(^{r_shift, w_vote});
                    if (w_bit_end) r_state <= S_STOP;
                end
                S_STOP: begin
                    // The last stop bit ends the frame at its sample point so the next start
                    // edge can be caught even when frames arrive back to back.
                    if (w_sample) begin
                        if (r_bit_cnt == STOP_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr <= r_ferr | ~w_vote;
                        end
                    end
                    if (w_bit_end) r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_done) begin
                if (!r_valid || bus.rx_ready) begin
                    r_data       <= r_shift;
                    r_frame_err  <= r_ferr | ~w_vote;
                    r_parity_err <= r_perr;
                    r_valid      <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data    = r_data;
    assign bus.rx_valid   = r_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.parity_err = r_parity_err;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = r_busy;
endmodule
